// File: rtl/rem_bcd_divider.sv
// Sequential restoring divider whose remainder is converted to BCD by shift-add-3.
// Optional LEADING_ZERO_BLANK_EN replaces leading zero remainder digits with 4'hC.
module rem_bcd_divider #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk_3,
  input  logic                  clr,
  input  logic                  start,
  input  logic [WIDTH-1:0]      dividend,
  input  logic [WIDTH-1:0]      divisor,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [WIDTH-1:0]      quotient,
  output logic [4*DIGITS-1:0]   rem_bcd
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, DIV, CONV, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [BW-1:0]    rem_bcd_q, rem_bcd_d;

  logic [WIDTH:0]   r_sh;
  logic [WIDTH-1:0] q_sh;
  logic [BW-1:0]    bcd_adj;
  logic [BW-1:0]    bcd_shift;
  logic             last_step;

`ifdef LEADING_ZERO_BLANK_EN
  function automatic logic [BW-1:0] blank_lz(input logic [BW-1:0] v);
    logic lead;
    blank_lz = v;
    lead     = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (lead && (v[4*i +: 4] == 4'h0)) blank_lz[4*i +: 4] = 4'hC;
      else                                lead = 1'b0;
    end
  endfunction
`endif

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    r_d        = r_q;
    q_d        = q_q;
    bcd_d      = bcd_q;
    err_d      = err_q;
    quotient_d = quotient_q;
    rem_bcd_d  = rem_bcd_q;

    last_step = (cnt_q == CW'(WIDTH - 1));
    r_sh      = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    q_sh      = {q_q[WIDTH-2:0], 1'b0};

    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_shift = {bcd_adj[BW-2:0], r_q[WIDTH-1]};

    case (state_q)
      IDLE: begin
        if (start) begin
          div_d = divisor;
          if (divisor == '0) begin
            state_d    = DONE;
            err_d      = 1'b1;
            quotient_d = '1;
            rem_bcd_d  = {DIGITS{4'hE}};
          end else begin
            state_d = DIV;
            cnt_d   = '0;
            r_d     = '0;
            q_d     = dividend;
          end
        end
      end
      DIV: begin
        if (r_sh >= {1'b0, div_q}) begin
          r_d = r_sh - {1'b0, div_q};
          q_d = {q_sh[WIDTH-1:1], 1'b1};
        end else begin
          r_d = r_sh;
          q_d = q_sh;
        end
        cnt_d = cnt_q + CW'(1);
        if (last_step) begin
          state_d = CONV;
          cnt_d   = '0;
          bcd_d   = '0;
        end
      end
      CONV: begin
        // The remainder is consumed MSB first out of r_q while the BCD register fills.
        bcd_d = bcd_shift;
        r_d   = {r_q[WIDTH-1:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (last_step) begin
          state_d    = DONE;
          cnt_d      = '0;
          err_d      = 1'b0;
          quotient_d = q_q;
`ifdef LEADING_ZERO_BLANK_EN
          rem_bcd_d  = blank_lz(bcd_shift);
`else
          rem_bcd_d  = bcd_shift;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == DIV) || (state_d == CONV);
    done_d = (state_q == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_3 or posedge clr) begin
    if (clr) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      r_q        <= '0;
      q_q        <= '0;
      bcd_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      quotient_q <= '0;
      rem_bcd_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      r_q        <= r_d;
      q_q        <= q_d;
      bcd_q      <= bcd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      quotient_q <= quotient_d;
      rem_bcd_q  <= rem_bcd_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign quotient = quotient_q;
  assign rem_bcd  = rem_bcd_q;

endmodule
